if_id_queue: RTL and testbench

Parametrised successor to the single-entry IF/ID pipeline register. It is a DEPTH-entry instruction queue between IF and ID that decouples fetch from decode.
- Ready/valid handshake on both sides.
- Same-cycle flush for branch redirect.
- Per-entry PC correction, so ID sees the address of the instruction itself rather than the post-increment fetch PC.

---
 rtl/if_id_queue_pkg.sv | 14 +
 rtl/if_id_queue_mem.sv | 18 +
 rtl/if_id_queue.sv | 73 +++++++
 tb/tb_if_id_queue.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: shared constants and bus types for the IF/ID instruction queue.
// Optional same-cycle bypass is enabled by defining IF_ID_QUEUE_BYPASS_EN.
package if_id_queue_pkg;
    localparam int   XLEN_DEF      = 32;
    localparam int   DEPTH_DEF     = 4;
    localparam int   PC_OFFSET_DEF = 4;
    localparam logic ENABLE        = 1'b1;
    localparam logic DISABLE       = 1'b0;
    localparam logic STOP          = 1'b1;
    localparam logic NO_STOP       = 1'b0;
    typedef logic [XLEN_DEF-1:0] inst_addr_t;
    typedef logic [XLEN_DEF-1:0] inst_t;
    localparam inst_t ZERO_WORD = '0;
endpackage

// File: rtl/if_id_queue_mem.sv
// if_id_queue_mem: DEPTH x W register array, one synchronous write port and one
// asynchronous read port; contents are deliberately not reset.
module if_id_queue_mem #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);
    logic [W-1:0] r_mem [DEPTH];
    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry IF/ID instruction queue with ready/valid, flush and PC correction.
// Define IF_ID_QUEUE_BYPASS_EN to let an empty queue forward IF straight to ID in the same cycle.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int PC_OFFSET = PC_OFFSET_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   stall_id,
    input  logic                   if_flag,
    input  logic [XLEN-1:0]        if_pc,
    input  logic [XLEN-1:0]        if_inst,
    output logic                   if_ready,
    output logic                   id_flag,
    output logic [XLEN-1:0]        id_pc,
    output logic [XLEN-1:0]        id_inst,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]     r_rd_ptr, r_wr_ptr;
    logic [AW:0]       r_count;
    logic              w_empty, w_push, w_wr, w_rd;
    logic [2*XLEN-1:0] w_wdata, w_rdata, w_head;

    assign w_empty  = r_count == '0;
    assign if_ready = (r_count == (AW+1)'(DEPTH)) ? DISABLE : ENABLE;
    assign w_push   = if_flag == ENABLE && if_ready && !flush;
    assign w_wdata  = {if_pc - XLEN'(PC_OFFSET), if_inst};
    assign w_rd     = !w_empty && stall_id != STOP && !flush;

`ifdef IF_ID_QUEUE_BYPASS_EN
    logic w_bypass;
    assign w_bypass = w_empty && if_flag && !flush;
    // A bypassed instruction that ID takes right away never touches storage
    assign w_wr     = w_push && !(w_bypass && stall_id == NO_STOP);
    assign w_head   = w_bypass ? w_wdata : w_rdata;
    assign id_flag  = !w_empty || w_bypass;
`else
    assign w_wr     = w_push;
    assign w_head   = w_rdata;
    assign id_flag  = !w_empty;
`endif

    assign id_pc   = id_flag ? w_head[2*XLEN-1:XLEN] : XLEN'(ZERO_WORD);
    assign id_inst = id_flag ? w_head[XLEN-1:0]      : XLEN'(ZERO_WORD);
    assign count   = r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end

    if_id_queue_mem #(.W(2*XLEN), .DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: scoreboard bench for if_id_queue (XLEN=32, DEPTH=4, PC_OFFSET=4).
// Expected head entries are queued as IF stimulus is accepted and compared as ID consumes them.
module tb_if_id_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
`ifdef IF_ID_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst, flush, stall_id, if_flag;
    logic [XLEN-1:0] if_pc, if_inst;
    logic            if_ready, id_flag;
    logic [XLEN-1:0] id_pc, id_inst;
    logic [2:0]      count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    if_id_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .PC_OFFSET(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_id(stall_id),
        .if_flag(if_flag), .if_pc(if_pc), .if_inst(if_inst),
        .if_ready(if_ready), .id_flag(id_flag), .id_pc(id_pc),
        .id_inst(id_inst), .count(count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and update the scoreboard from the inputs applied across it
    task automatic edge_step();
        bit byp, psh, pp;
        byp = BYP && exp_q.size() == 0 && if_flag && !flush;
        psh = if_flag && exp_q.size() < DEPTH && !flush;
        pp  = exp_q.size() != 0 && !stall_id && !flush;
        @(posedge clk);
        if (flush) exp_q.delete();
        else begin
            if (pp) void'(exp_q.pop_front());
            if (psh && !(byp && !stall_id)) exp_q.push_back({if_pc - 32'd4, if_inst});
        end
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_checks++; if (id_flag !== 1'b0) begin n_fail++; $display("FAIL reset_id_flag got %b exp 0", id_flag); end
        n_checks++; if (id_pc !== 32'h0 || id_inst !== 32'h0) begin n_fail++; $display("FAIL reset_head got %h/%h exp 0/0", id_pc, id_inst); end
        n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL reset_if_ready got %b exp 1", if_ready); end
        #1 rst = 1'b1;
    endtask

    task automatic test_async_reset();
        stall_id = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_flag = 1'b1; if_pc = 32'h204 + 32'(4*i); if_inst = 32'hA000 + 32'(i);
            edge_step();
        end
        if_flag = 1'b0;
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL ar_pre_count got %0d exp 3", count); end
        #3 rst = 1'b0;
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL ar_count got %0d exp 0", count); end
        n_checks++; if (id_flag !== 1'b0 || id_pc !== 32'h0) begin n_fail++; $display("FAIL ar_head got %b/%h exp 0/0", id_flag, id_pc); end
        n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL ar_if_ready got %b exp 1", if_ready); end
        exp_q.delete();
        #1 rst = 1'b1;
        if_flag = 1'b1; if_pc = 32'h304; if_inst = 32'hB000;
        edge_step();
        if_flag = 1'b0;
        n_checks++; if (count !== 3'd1 || id_pc !== 32'h300) begin n_fail++; $display("FAIL ar_first_push got %0d/%h exp 1/300", count, id_pc); end
        stall_id = 1'b0;
        edge_step();
    endtask

    task automatic test_single_push();
        stall_id = 1'b0;
        if_flag = 1'b1; if_pc = 32'h104; if_inst = 32'h0050_0093;
        #1;
`ifdef IF_ID_QUEUE_BYPASS_EN
        n_checks++; if (id_flag !== 1'b1 || id_pc !== 32'h100 || id_inst !== 32'h0050_0093) begin n_fail++; $display("FAIL sp_bypass got %b/%h/%h exp 1/100/00500093", id_flag, id_pc, id_inst); end
        edge_step();
        if_flag = 1'b0;
`else
        n_checks++; if (id_flag !== 1'b0) begin n_fail++; $display("FAIL sp_latency got %b exp 0", id_flag); end
        edge_step();
        if_flag = 1'b0;
        #1;
        n_checks++; if (id_flag !== 1'b1 || id_pc !== 32'h100 || id_inst !== 32'h0050_0093) begin n_fail++; $display("FAIL sp_head got %b/%h/%h exp 1/100/00500093", id_flag, id_pc, id_inst); end
        n_checks++; if ({id_pc, id_inst} !== exp_q[0]) begin n_fail++; $display("FAIL sp_sb got %h%h exp %h", id_pc, id_inst, exp_q[0]); end
        edge_step();
`endif
        n_checks++; if (id_flag !== 1'b0 || count !== 3'd0 || id_pc !== 32'h0 || id_inst !== 32'h0) begin n_fail++; $display("FAIL sp_empty got %b/%0d/%h/%h exp 0/0/0/0", id_flag, count, id_pc, id_inst); end
    endtask

    task automatic test_fill_full();
        stall_id = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if_flag = 1'b1; if_pc = 32'(4*(i+1)); if_inst = 32'h1000 + 32'(i);
            #1;
            n_checks++; if (if_ready !== (i < 4)) begin n_fail++; $display("FAIL ff_ready_%0d got %b exp %b", i, if_ready, i < 4); end
            edge_step();
        end
        if_flag = 1'b0;
        n_checks++; if (count !== 3'd4 || if_ready !== 1'b0) begin n_fail++; $display("FAIL ff_full got %0d/%b exp 4/0", count, if_ready); end
        stall_id = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (id_flag !== 1'b1 || id_pc !== 32'(4*i) || {id_pc, id_inst} !== exp_q[0]) begin n_fail++; $display("FAIL ff_pop_%0d got %b/%h exp 1/%h", i, id_flag, id_pc, 32'(4*i)); end
            edge_step();
        end
        n_checks++; if (count !== 3'd0 || id_flag !== 1'b0) begin n_fail++; $display("FAIL ff_drained got %0d/%b exp 0/0", count, id_flag); end
    endtask

    task automatic test_wrap();
        stall_id = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if_flag = 1'b1; if_pc = 32'h2000 + 32'(4*i); if_inst = 32'hC000 + 32'(i);
            edge_step();
        end
        stall_id = 1'b0;
        for (int i = 2; i < 12; i++) begin
            if_flag = 1'b1; if_pc = 32'h2000 + 32'(4*i); if_inst = 32'hC000 + 32'(i);
            #1;
            n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL wr_count_%0d got %0d exp 2", i, count); end
            n_checks++; if (id_flag !== 1'b1 || {id_pc, id_inst} !== exp_q[0]) begin n_fail++; $display("FAIL wr_head_%0d got %h%h exp %h", i, id_pc, id_inst, exp_q[0]); end
            edge_step();
        end
        if_flag = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if (id_flag !== 1'b1 || {id_pc, id_inst} !== exp_q[0]) begin n_fail++; $display("FAIL wr_drain_%0d got %h%h exp %h", i, id_pc, id_inst, exp_q[0]); end
            edge_step();
        end
    endtask

    task automatic test_flush();
        stall_id = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_flag = 1'b1; if_pc = 32'h3004 + 32'(4*i); if_inst = 32'hD000 + 32'(i);
            edge_step();
        end
        if_flag = 1'b1; if_pc = 32'h3104; if_inst = 32'hDEAD; stall_id = 1'b0; flush = 1'b1;
        #1;
        n_checks++; if (id_flag !== 1'b1 || count !== 3'd3) begin n_fail++; $display("FAIL fl_pre got %b/%0d exp 1/3", id_flag, count); end
        edge_step();
        flush = 1'b0; if_flag = 1'b0;
        n_checks++; if (count !== 3'd0 || id_flag !== 1'b0 || id_pc !== 32'h0) begin n_fail++; $display("FAIL fl_post got %0d/%b/%h exp 0/0/0", count, id_flag, id_pc); end
        stall_id = 1'b1;
        if_flag = 1'b1; if_pc = 32'h4004; if_inst = 32'hE000;
        edge_step();
        if_flag = 1'b0;
        n_checks++; if (count !== 3'd1 || id_pc !== 32'h4000 || id_inst !== 32'hE000) begin n_fail++; $display("FAIL fl_next got %0d/%h/%h exp 1/4000/e000", count, id_pc, id_inst); end
        stall_id = 1'b0;
        edge_step();
    endtask

    task automatic test_pc_wrap();
        stall_id = 1'b1;
        if_flag = 1'b1; if_pc = 32'h0; if_inst = 32'hF00D;
        edge_step();
        if_flag = 1'b0;
        n_checks++; if (id_pc !== 32'hFFFF_FFFC || {id_pc, id_inst} !== exp_q[0]) begin n_fail++; $display("FAIL pcw_head got %h exp fffffffc", id_pc); end
        stall_id = 1'b0;
        edge_step();
    endtask

    task automatic test_bypass();
        stall_id = 1'b0;
        if_flag = 1'b1; if_pc = 32'h5008; if_inst = 32'h1234;
        #1;
        n_checks++; if (id_flag !== BYP) begin n_fail++; $display("FAIL bp_same_cycle got %b exp %b", id_flag, BYP); end
        edge_step();
        if_flag = 1'b0;
        n_checks++; if (count !== (BYP ? 3'd0 : 3'd1)) begin n_fail++; $display("FAIL bp_count got %0d exp %0d", count, BYP ? 0 : 1); end
        n_checks++; if (id_flag !== !BYP) begin n_fail++; $display("FAIL bp_next_cycle got %b exp %b", id_flag, !BYP); end
        if (id_flag) begin
            n_checks++; if (id_pc !== 32'h5004 || {id_pc, id_inst} !== exp_q[0]) begin n_fail++; $display("FAIL bp_head got %h exp 5004", id_pc); end
        end
        edge_step();
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; stall_id = 1'b0; if_flag = 1'b0;
        if_pc = '0; if_inst = '0;
        test_reset();
        test_single_push();
        test_fill_full();
        test_wrap();
        test_flush();
        test_async_reset();
        test_pc_wrap();
        test_bypass();
        n_checks++; if (exp_q.size() != 0 || count !== 3'd0) begin n_fail++; $display("FAIL final_empty got %0d/%0d exp 0/0", count, exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
